pet_action_encoder: RTL and testbench

PET_ACTION_ENCODER -- requirements
Module: pet_action_encoder

---
 rtl/pet_action_encoder.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_pet_action_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pet_action_encoder.sv
// rtl/pet_action_encoder.sv - button front end turning raw pet buttons into action, mode and reset pulses

// Two-flop synchronizer plus counter debounce for one active-low button.
// level_o is the debounced "pressed" level (active-high).
module pet_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic level_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          pressed_sync;

  // Raw button is stored as-is; inversion to "pressed" happens after the second flop.
  assign pressed_sync = ~sync2_q;

  // Synchronizer chain for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreement; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (pressed_sync != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = pressed_sync;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// Press/hold/release FSM for one button. fire_o is the combinational
// "emit now" strobe; the top registers it into the visible pulse.
module pet_hold_fsm #(
  parameter int HOLD_TICKS = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  input  logic tick_i,
  input  logic fast_i,
  output logic fire_o
);

  // Out-of-range hold lengths are clamped into the 5-bit counter range.
  localparam int HOLD_LIM = (HOLD_TICKS < 1) ? 1 : ((HOLD_TICKS > 31) ? 31 : HOLD_TICKS);
  localparam logic [4:0] HOLD_CMP = 5'(HOLD_LIM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] cnt_q;
  logic [4:0] cnt_d;
  logic [4:0] cnt_inc;
  logic       prev_q;
  logic       press;
  logic       fire_d;

  assign press   = level_i & ~prev_q;
  assign cnt_inc = (cnt_q == 5'd31) ? cnt_q : (cnt_q + 5'd1);

  // Next state, hold count and emit strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          cnt_d = 5'd0;
          if (fast_i) begin
            fire_d  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!level_i) begin
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else if (tick_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == HOLD_CMP) begin
            fire_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!level_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, hold counter and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= level_i;
    end
  end

  assign fire_o = fire_d;

endmodule

// Top: six debounced buttons, shared tick, four action channels,
// test-mode toggle and the reset-request channel.
module pet_action_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 12500000,
  parameter int HOLD_TICKS      = 15,
  parameter int RST_TICKS       = 5
) (
  input  logic clk,
  input  logic reseteo,
  input  logic btn_carino,
  input  logic btn_comida,
  input  logic btn_medicina,
  input  logic btn_dormir,
  input  logic btn_test,
  input  logic btn_reset,
  output logic Carino,
  output logic Comida,
  output logic Medicina,
  output logic Dormir,
  output logic modo_test,
  output logic rst_req,
  output logic tick
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX = (TICK_CYCLES > 1) ? TW'(TICK_CYCLES - 1) : '0;

  logic [5:0]    btn_n;
  logic [5:0]    level;
  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          tick_now;
  logic [3:0]    act_fire;
  logic [3:0]    act_q;
  logic          rst_fire;
  logic          rst_req_q;
  logic          test_prev_q;
  logic          test_press;
  logic          modo_q;
  logic          modo_d;

  // Channel order: 0 carino, 1 comida, 2 medicina, 3 dormir, 4 test, 5 reset.
  assign btn_n = {btn_reset, btn_test, btn_dormir, btn_medicina, btn_comida, btn_carino};

  genvar gi;
  for (gi = 0; gi < 6; gi++) begin : g_deb
    pet_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (reseteo),
      .btn_n_i(btn_n[gi]),
      .level_o(level[gi])
    );
  end

  // Free-running tick divider; tick is forced low while reset is held.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_MAX) ? '0 : (tick_cnt_q + TW'(1));
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_now = (tick_cnt_q == TICK_MAX) & ~reseteo;

  for (gi = 0; gi < 4; gi++) begin : g_act
    pet_hold_fsm #(
      .HOLD_TICKS(HOLD_TICKS)
    ) u_fsm (
      .clk    (clk),
      .rst    (reseteo),
      .level_i(level[gi]),
      .tick_i (tick_now),
      .fast_i (modo_q),
      .fire_o (act_fire[gi])
    );
  end

  // Reset-request channel never takes the test-mode shortcut.
  pet_hold_fsm #(
    .HOLD_TICKS(RST_TICKS)
  ) u_rst_fsm (
    .clk    (clk),
    .rst    (reseteo),
    .level_i(level[5]),
    .tick_i (tick_now),
    .fast_i (1'b0),
    .fire_o (rst_fire)
  );

  assign test_press = level[4] & ~test_prev_q;

  // Test mode toggles per press; a reset request clears it and wins a tie.
  always_comb begin
    modo_d = modo_q;
    if (rst_fire) begin
      modo_d = 1'b0;
    end else if (test_press) begin
      modo_d = ~modo_q;
    end
  end

  // Output pulse registers and test-mode state.
  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      act_q       <= 4'd0;
      rst_req_q   <= 1'b0;
      modo_q      <= 1'b0;
      test_prev_q <= 1'b0;
    end else begin
      act_q       <= act_fire;
      rst_req_q   <= rst_fire;
      modo_q      <= modo_d;
      test_prev_q <= level[4];
    end
  end

  assign Carino    = act_q[0];
  assign Comida    = act_q[1];
  assign Medicina  = act_q[2];
  assign Dormir    = act_q[3];
  assign modo_test = modo_q;
  assign rst_req   = rst_req_q;
  assign tick      = tick_now;

endmodule

// File: tb/tb_pet_action_encoder.sv
// tb/tb_pet_action_encoder.sv - randomized and directed bench for pet_action_encoder against a reference model
module tb_pet_action_encoder;

  localparam int D = 4;
  localparam int T = 10;
  localparam int H = 3;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reseteo = 1'b1;
  logic [5:0] btn = 6'h3f;
  logic       Carino, Comida, Medicina, Dormir, modo_test, rst_req, tick;

  pet_action_encoder #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES(T),
    .HOLD_TICKS(H),
    .RST_TICKS(R)
  ) dut (
    .clk         (clk),
    .reseteo     (reseteo),
    .btn_carino  (btn[0]),
    .btn_comida  (btn[1]),
    .btn_medicina(btn[2]),
    .btn_dormir  (btn[3]),
    .btn_test    (btn[4]),
    .btn_reset   (btn[5]),
    .Carino      (Carino),
    .Comida      (Comida),
    .Medicina    (Medicina),
    .Dormir      (Dormir),
    .modo_test   (modo_test),
    .rst_req     (rst_req),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;
  int since = 0;
  int n_pulse [6];
  int first_pulse [6];
  bit modo_at_rst;

  // Reference model: raw-sample delay line, stable-run debounce, and per-press hold bookkeeping.
  bit m_s1 [6];
  bit m_s2 [6];
  bit m_deb [6];
  bit m_prev [6];
  int m_run [6];
  int m_tcnt;
  int m_ph [6];      // 0 waiting for press, 1 holding, 2 already served this press
  int m_ticks [6];
  bit m_pulse [6];
  bit m_modo;

  function automatic void model_reset();
    for (int c = 0; c < 6; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0; m_prev[c] = 0; m_run[c] = 0;
      m_ph[c] = 0; m_ticks[c] = 0; m_pulse[c] = 0;
    end
    m_tcnt = 0;
    m_modo = 0;
  endfunction

  function automatic void model_edge();
    bit nd [6];
    int nr [6];
    bit fire [6];
    bit edge_ [6];
    bit tk;
    if (reseteo) begin
      model_reset();
      return;
    end
    tk = (m_tcnt == T - 1);
    for (int c = 0; c < 6; c++) begin
      bit p;
      p = !m_s2[c];
      edge_[c] = m_deb[c] && !m_prev[c];
      nd[c] = m_deb[c];
      nr[c] = 0;
      if (p != m_deb[c]) begin
        if (m_run[c] >= D) nd[c] = p;
        else nr[c] = m_run[c] + 1;
      end
      fire[c] = 0;
    end
    for (int c = 0; c < 6; c++) begin
      int lim;
      bit fast;
      if (c == 4) continue;
      lim  = (c == 5) ? R : H;
      fast = (c == 5) ? 1'b0 : m_modo;
      if (m_ph[c] == 0) begin
        if (edge_[c]) begin
          m_ticks[c] = 0;
          if (fast) begin fire[c] = 1; m_ph[c] = 2; end
          else m_ph[c] = 1;
        end
      end else if (m_ph[c] == 1) begin
        if (!m_deb[c]) m_ph[c] = 0;
        else if (tk) begin
          m_ticks[c] = (m_ticks[c] >= 31) ? 31 : m_ticks[c] + 1;
          if (m_ticks[c] == lim) begin fire[c] = 1; m_ph[c] = 2; end
        end
      end else begin
        if (!m_deb[c]) m_ph[c] = 0;
      end
    end
    if (fire[5]) m_modo = 0;
    else if (edge_[4]) m_modo = !m_modo;
    for (int c = 0; c < 6; c++) begin
      m_prev[c]  = m_deb[c];
      m_deb[c]   = nd[c];
      m_run[c]   = nr[c];
      m_s2[c]    = m_s1[c];
      m_s1[c]    = btn[c];
      m_pulse[c] = fire[c];
    end
    m_tcnt = (m_tcnt == T - 1) ? 0 : m_tcnt + 1;
  endfunction

  function automatic logic [6:0] got_vec();
    return {tick, rst_req, modo_test, Dormir, Medicina, Comida, Carino};
  endfunction

  function automatic logic [6:0] exp_vec();
    logic t;
    t = !reseteo && (m_tcnt == T - 1);
    return {t, m_pulse[5], m_modo, m_pulse[3], m_pulse[2], m_pulse[1], m_pulse[0]};
  endfunction

  task automatic check_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic clear_stats();
    since = 0;
    for (int c = 0; c < 6; c++) begin
      n_pulse[c] = 0;
      first_pulse[c] = -1;
    end
  endtask

  // One clock: advance model at the edge, compare all outputs 1 time unit later.
  task automatic cyc();
    logic [6:0] g;
    logic [6:0] e;
    @(posedge clk);
    model_edge();
    #1;
    cyc_no++;
    since++;
    g = got_vec();
    e = exp_vec();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL outputs cycle=%0d got=%b expected=%b (tick,rst_req,modo,dor,med,com,car)", cyc_no, g, e);
    end
    for (int c = 0; c < 4; c++) begin
      if (g[c]) begin
        n_pulse[c]++;
        if (first_pulse[c] < 0) first_pulse[c] = since;
      end
    end
    if (rst_req) begin
      n_pulse[5]++;
      if (first_pulse[5] < 0) first_pulse[5] = since;
      modo_at_rst = modo_test;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  int dur [6];

  initial begin
    model_reset();
    clear_stats();
    modo_at_rst = 1'b1;
    // Reset state
    run(3);
    check_lit("reset_outputs", int'(got_vec()), 0);

    // Clean press held through reset release: pulse on the third tick
    btn[0] = 1'b0;
    reseteo = 1'b0;
    clear_stats();
    run(60);
    check_lit("clean_carino_count", n_pulse[0], 1);
    check_lit("clean_carino_cycle", first_pulse[0], 30);
    check_lit("clean_others", n_pulse[1] + n_pulse[2] + n_pulse[3] + n_pulse[5], 0);
    btn[0] = 1'b1;
    run(20);

    // Bounce on dormir
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      btn[3] = ~btn[3];
      run(2);
    end
    btn[3] = 1'b1;
    run(40);
    check_lit("bounce_dormir", n_pulse[3], 0);

    // Short press then long hold on comida
    clear_stats();
    btn[1] = 1'b0; run(20);
    btn[1] = 1'b1; run(20);
    check_lit("short_comida", n_pulse[1], 0);
    btn[1] = 1'b0; run(40);
    btn[1] = 1'b1; run(20);
    check_lit("long_comida", n_pulse[1], 1);

    // Test mode and fast medicina
    btn[4] = 1'b0; run(12);
    btn[4] = 1'b1; run(12);
    check_lit("modo_on", int'(modo_test), 1);
    clear_stats();
    btn[2] = 1'b0; run(50);
    check_lit("fast_med_cycle", first_pulse[2], 8);
    check_lit("fast_med_count", n_pulse[2], 1);
    btn[2] = 1'b1; run(15);
    clear_stats();
    btn[2] = 1'b0; run(30);
    check_lit("fast_med_repress", n_pulse[2], 1);
    btn[2] = 1'b1; run(15);

    // Reset request clears test mode on the same edge
    clear_stats();
    btn[5] = 1'b0; run(30);
    check_lit("rst_req_count", n_pulse[5], 1);
    check_lit("modo_at_rst_req", int'(modo_at_rst), 0);
    btn[5] = 1'b1; run(15);
    check_lit("modo_after_rst", int'(modo_test), 0);

    // Async reset mid-hold
    clear_stats();
    btn[0] = 1'b0; run(15);
    check_lit("pre_async_carino", n_pulse[0], 0);
    #3;
    reseteo = 1'b1;
    model_reset();
    #1;
    check_lit("async_outputs", int'(got_vec()), 0);
    run(3);
    reseteo = 1'b0;
    clear_stats();
    run(50);
    check_lit("post_async_count", n_pulse[0], 1);
    check_lit("post_async_cycle", first_pulse[0], 30);
    btn[0] = 1'b1; run(20);

    // Randomized button activity with occasional resets
    for (int c = 0; c < 6; c++) dur[c] = $urandom_range(5, 60);
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 6; c++) begin
        if (dur[c] <= 0) begin
          btn[c] = ~btn[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(6, 70);
        end else begin
          dur[c]--;
        end
      end
      if (!reseteo && $urandom_range(0, 499) == 0) reseteo = 1'b1;
      else if (reseteo) reseteo = 1'b0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
